// File: rtl/fu_issue_ctrl.sv
// Issue controller for one two-operand functional unit: buffers operands, fires when both
// are present and a downstream credit exists, registers the result, and holds a serial opcode.
module fu_issue_ctrl #(
    parameter int DW      = 32,
    parameter int CREDITS = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_en,
    input  logic          cfg_in,
    output logic          cfg_out,
    input  logic          a_valid,
    input  logic          a_pred,
    input  logic [DW-1:0] a_data,
    output logic          a_credit,
    input  logic          b_valid,
    input  logic          b_pred,
    input  logic [DW-1:0] b_data,
    output logic          b_credit,
    output logic [1:0]    fu_conf,
    output logic [DW-1:0] fu_a,
    output logic [DW-1:0] fu_b,
    input  logic [DW-1:0] fu_res,
    input  logic          fu_pred,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_pred,
    input  logic          out_credit,
    output logic          err
);

    typedef enum logic [1:0] {S_OFF, S_CFG, S_RUN} state_t;

    localparam logic [1:0] CREDIT_INIT = 2'(CREDITS);

    state_t       state, state_nxt;
    logic [2:0]   cfg_reg;
    logic [DW:0]  mem [2][2];
    logic [1:0]   cnt [2];
    logic [DW:0]  din [2];
    logic [1:0]   push, pop, ovf;
    logic         fire, credit_err;
    logic [1:0]   credit_cnt;

    assign din[0]  = {a_pred, a_data};
    assign din[1]  = {b_pred, b_data};
    assign push    = {b_valid, a_valid};
    assign cfg_out = cfg_reg[0];
    assign fu_conf = cfg_reg[1:0];
    assign fu_a    = (cnt[0] != 2'd0) ? mem[0][0][DW-1:0] : '0;
    assign fu_b    = (cnt[1] != 2'd0) ? mem[1][0][DW-1:0] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_OFF;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cfg_en)
            state_nxt = S_CFG;
        else if (state == S_CFG)
            state_nxt = cfg_reg[2] ? S_RUN : S_OFF;
    end

    // S_OFF drains each buffer independently so upstream gets every slot back.
    always_comb begin
        fire = (state == S_RUN) && (cnt[0] != 2'd0) && (cnt[1] != 2'd0) && (credit_cnt != 2'd0);
        for (int i = 0; i < 2; i++) begin
            pop[i] = fire || ((state == S_OFF) && (cnt[i] != 2'd0));
            ovf[i] = push[i] && !pop[i] && (cnt[i] == 2'd2);
        end
        credit_err = out_credit && !fire && (credit_cnt == CREDIT_INIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cfg_reg <= 3'b000;
        else if (cfg_en) cfg_reg <= {cfg_in, cfg_reg[2:1]};
    end

    // Pop is applied before push, so a full buffer may accept a push in a popping cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                cnt[i]    <= 2'd0;
                mem[i][0] <= '0;
                mem[i][1] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case ({push[i], pop[i]})
                    2'b10: if (cnt[i] != 2'd2) begin
                        mem[i][cnt[i][0]] <= din[i];
                        cnt[i]            <= cnt[i] + 2'd1;
                    end
                    2'b01: begin
                        mem[i][0] <= mem[i][1];
                        cnt[i]    <= cnt[i] - 2'd1;
                    end
                    2'b11: if (cnt[i] == 2'd1) begin
                        mem[i][0] <= din[i];
                    end else begin
                        mem[i][0] <= mem[i][1];
                        mem[i][1] <= din[i];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_cnt <= CREDIT_INIT;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_pred   <= 1'b0;
            a_credit   <= 1'b0;
            b_credit   <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (fire && !out_credit)
                credit_cnt <= credit_cnt - 2'd1;
            else if (!fire && out_credit && credit_cnt != CREDIT_INIT)
                credit_cnt <= credit_cnt + 2'd1;
            out_valid <= fire;
            if (fire) begin
                out_data <= fu_res;
                out_pred <= fu_pred;
            end
            a_credit <= pop[0];
            b_credit <= pop[1];
            if ((|ovf) || credit_err) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Directed bench for fu_issue_ctrl; stimulus queues expected results, a negedge monitor checks them.
module tb_fu_issue_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_en = 1'b0, cfg_in = 1'b0, cfg_out;
    logic          a_valid = 1'b0, a_pred = 1'b0, a_credit;
    logic [DW-1:0] a_data = '0;
    logic          b_valid = 1'b0, b_pred = 1'b0, b_credit;
    logic [DW-1:0] b_data = '0;
    logic [1:0]    fu_conf;
    logic [DW-1:0] fu_a, fu_b, fu_res, out_data;
    logic          fu_pred, out_valid, out_pred, err;
    logic          out_credit = 1'b0;

    int checks = 0;
    int passes = 0;
    int valid_count = 0;
    int vc0;
    logic [DW:0] exp_q [$];
    logic [DW:0] e;

    // FU model: opcode 00 is an adder; predicate is the xor of operand LSBs.
    assign fu_res  = fu_a + fu_b;
    assign fu_pred = fu_a[0] ^ fu_b[0];

    always #5 clk = ~clk;

    fu_issue_ctrl #(.DW(DW), .CREDITS(2)) dut (
        .clk(clk), .rst(rst),
        .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cfg_out),
        .a_valid(a_valid), .a_pred(a_pred), .a_data(a_data), .a_credit(a_credit),
        .b_valid(b_valid), .b_pred(b_pred), .b_data(b_data), .b_credit(b_credit),
        .fu_conf(fu_conf), .fu_a(fu_a), .fu_b(fu_b), .fu_res(fu_res), .fu_pred(fu_pred),
        .out_valid(out_valid), .out_data(out_data), .out_pred(out_pred),
        .out_credit(out_credit), .err(err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && out_valid) begin
            valid_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(e[DW-1:0]));
                chk("out_pred", 64'(out_pred), 64'(e[DW]));
                chk("a_credit_with_result", 64'(a_credit), 64'd1);
                chk("b_credit_with_result", 64'(b_credit), 64'd1);
            end
        end
    end

    task automatic load_cfg(input logic [2:0] v);
        cfg_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cfg_in = v[i];
            tick();
        end
        cfg_en = 1'b0;
        tick();
    endtask

    task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] sum, input logic p);
        a_valid = 1'b1; a_data = a;
        b_valid = 1'b1; b_data = b;
        exp_q.push_back({p, sum});
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic push_a(input logic [DW-1:0] a);
        a_valid = 1'b1; a_data = a;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic push_b(input logic [DW-1:0] b, input logic [DW-1:0] sum, input logic p);
        b_valid = 1'b1; b_data = b;
        exp_q.push_back({p, sum});
        tick();
        b_valid = 1'b0;
    endtask

    task automatic give_credit();
        out_credit = 1'b1;
        tick();
        out_credit = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_fu_a", 64'(fu_a), 64'd0);
        chk("rst_fu_conf", 64'(fu_conf), 64'd0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("reset_cfg_out", 64'(cfg_out), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_a_credit", 64'(a_credit), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // Config load 0,1,1 (LSB first) gives cfg_reg=110
        cfg_en = 1'b1;
        cfg_in = 1'b0; tick(); chk("cfg_out_c0", 64'(cfg_out), 64'd0);
        cfg_in = 1'b1; tick(); chk("cfg_out_c1", 64'(cfg_out), 64'd0);
        cfg_in = 1'b1; tick(); chk("cfg_out_c2", 64'(cfg_out), 64'd0);
        cfg_en = 1'b0;
        chk("fu_conf_110", 64'(fu_conf), 64'd2);
        tick();
        load_cfg(3'b100);
        chk("fu_conf_100", 64'(fu_conf), 64'd0);

        // Single op: A=5 in cycle 0, B=7 in cycle 2
        push_a(32'd5);
        tick();
        push_b(32'd7, 32'd12, 1'b0);
        chk("single_fu_a", 64'(fu_a), 64'd5);
        chk("single_fu_b", 64'(fu_b), 64'd7);
        chk("single_no_early_valid", 64'(out_valid), 64'd0);
        tick();
        chk("single_out_valid", 64'(out_valid), 64'd1);
        chk("single_a_credit", 64'(a_credit), 64'd1);
        give_credit();

        // Credit stall: three back-to-back pairs with two credits
        vc0 = valid_count;
        push_pair(32'd1, 32'd2, 32'd3, 1'b1);
        push_pair(32'd3, 32'd4, 32'd7, 1'b1);
        push_pair(32'd10, 32'd20, 32'd30, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("stall_pulses", 64'(valid_count - vc0), 64'd2);
        chk("stall_held_a", 64'(fu_a), 64'd10);
        give_credit();
        chk("stall_release_wait", 64'(out_valid), 64'd0);
        tick();
        chk("stall_release_valid", 64'(out_valid), 64'd1);
        give_credit();
        give_credit();
        chk("stall_no_err", 64'(err), 64'd0);

        // Simultaneous fire and out_credit at credit_cnt=1
        push_pair(32'd6, 32'd9, 32'd15, 1'b1);
        tick();
        tick();
        push_pair(32'd100, 32'd1, 32'd101, 1'b1);
        give_credit();
        tick();
        give_credit();
        chk("simul_no_err", 64'(err), 64'd0);
        give_credit();
        chk("credit_overflow_err", 64'(err), 64'd1);
        tick();

        // Reset mid-operation discards a buffered operand
        push_a(32'd77);
        chk("pre_reset_fu_a", 64'(fu_a), 64'd77);
        do_reset();
        tick();
        chk("post_reset_fu_a", 64'(fu_a), 64'd0);
        load_cfg(3'b100);

        // Overflow: third A push into full buffer is dropped
        push_a(32'd1);
        push_a(32'd2);
        chk("ovf_err_before", 64'(err), 64'd0);
        push_a(32'd3);
        chk("ovf_err_after", 64'(err), 64'd1);
        chk("ovf_head", 64'(fu_a), 64'd1);
        push_b(32'd10, 32'd11, 1'b1);
        push_b(32'd20, 32'd22, 1'b0);
        tick();
        tick();
        chk("ovf_a_empty", 64'(fu_a), 64'd0);
        give_credit();
        give_credit();

        // Disable drain: two A entries, reload with enable=0
        push_a(32'd40);
        push_a(32'd41);
        vc0 = valid_count;
        load_cfg(3'b000);
        chk("drain_c0_credit", 64'(a_credit), 64'd0);
        chk("drain_c0_head", 64'(fu_a), 64'd40);
        tick();
        chk("drain_c1_credit", 64'(a_credit), 64'd1);
        chk("drain_c1_head", 64'(fu_a), 64'd41);
        tick();
        chk("drain_c2_credit", 64'(a_credit), 64'd1);
        chk("drain_empty", 64'(fu_a), 64'd0);
        tick();
        chk("drain_c3_credit", 64'(a_credit), 64'd0);
        chk("drain_no_valid", 64'(valid_count - vc0), 64'd0);

        tick();
        chk("results_all_seen", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
